// File: rtl/jk_cmd_sequencer.sv
// Command FIFO and replay FSM driving the j/k inputs of a bank of JK flip-flops.
// Each queued set/reset/toggle/hold command is applied for cmd_rpt+1 consecutive cycles.
module jk_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_mask,
    input  logic [CNT_W-1:0]         cmd_rpt,
    output logic [WIDTH-1:0]         j,
    output logic [WIDTH-1:0]         k,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 + WIDTH + CNT_W;

    typedef enum logic {IDLE, APPLY} state_t;

    state_t             state;
    logic [CNT_W-1:0]   remaining;
    logic [EW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;
    logic               cmd_end;
    logic [1:0]         head_op;
    logic [WIDTH-1:0]   head_mask;
    logic [CNT_W-1:0]   head_rpt;

    always_comb begin
        cmd_ready = reset && (fifo_count < CW'(DEPTH));
        push      = cmd_valid && cmd_ready;
        cmd_end   = (state == APPLY) && (remaining == '0);
        // Pop looks only at the pre-edge occupancy, so a fresh push is never bypassed.
        pop       = (fifo_count != '0) && ((state == IDLE) || cmd_end);
        {head_op, head_mask, head_rpt} = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_op, cmd_mask, cmd_rpt};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            j         <= '0;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= cmd_end;
            if (pop) begin
                state     <= APPLY;
                remaining <= head_rpt;
                j         <= {WIDTH{head_op[1]}} & head_mask;
                k         <= {WIDTH{head_op[0]}} & head_mask;
                busy      <= 1'b1;
            end else if ((state == IDLE) || cmd_end) begin
                state <= IDLE;
                j     <= '0;
                k     <= '0;
                busy  <= 1'b0;
            end else begin
                remaining <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: directed scenarios plus random traffic,
// compared against a queue-based reference model of the command stream.
module tb_jk_cmd_sequencer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] mask;
        logic [CNT_W-1:0] rpt;
    } cmd_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = '0;
    logic [WIDTH-1:0] cmd_mask = '0;
    logic [CNT_W-1:0] cmd_rpt = '0;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic [2:0]       fifo_count;

    int checks = 0;
    int failures = 0;

    // Reference model: pending commands, the active one, and cycles it still has to show.
    cmd_t q[$];
    cmd_t cur;
    bit   act = 0;
    int   left = 0;
    bit   e_done = 0;
    bit   last_acc = 0;

    jk_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_rpt(cmd_rpt),
        .j(j), .k(k), .busy(busy), .done(done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ready();
        return reset && (q.size() < DEPTH);
    endfunction

    function automatic logic [2*WIDTH+4:0] model_vec();
        logic [WIDTH-1:0] ej, ek;
        ej = act ? ({WIDTH{cur.op[1]}} & cur.mask) : '0;
        ek = act ? ({WIDTH{cur.op[0]}} & cur.mask) : '0;
        return {ej, ek, act, e_done, 3'(q.size())};
    endfunction

    task automatic set_cmd(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] m,
                           input logic [CNT_W-1:0] r);
        cmd_valid = v; cmd_op = op; cmd_mask = m; cmd_rpt = r;
        #1;
    endtask

    // Advance DUT and model by one clock; outputs are stable #1 after the edge.
    task automatic step();
        cmd_t c;
        bit acc;
        acc = cmd_valid && exp_ready();
        c = '{op: cmd_op, mask: cmd_mask, rpt: cmd_rpt};
        @(posedge clk);
        if (!reset) begin
            q.delete(); act = 0; e_done = 0; acc = 0;
        end else begin
            e_done = act && (left == 1);
            if (act) begin
                left--;
                if (left == 0) act = 0;
            end
            if (!act && q.size() > 0) begin
                cur = q.pop_front(); act = 1; left = int'(cur.rpt) + 1;
            end
            if (acc) q.push_back(c);
        end
        last_acc = acc;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_cmd(1'b1, 2'b10, 4'hF, 4'h0);
        step(); step();
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", cmd_ready); end
        checks++;
        if ({j, k, busy, done, fifo_count} !== 13'b0) begin
            failures++; $display("FAIL reset_state got j=%h k=%h busy=%b done=%b cnt=%0d exp all zero", j, k, busy, done, fifo_count);
        end
        reset = 1'b1;
        set_cmd(1'b0, 2'b00, 4'h0, 4'h0);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_single_set();
        set_cmd(1'b1, 2'b10, 4'b0101, 4'h0);
        step();
        set_cmd(1'b0, 2'b00, 4'h0, 4'h0);
        checks++;
        if ({j, k, fifo_count} !== {4'h0, 4'h0, 3'd1}) begin
            failures++; $display("FAIL single_latency got j=%h k=%h cnt=%0d exp j=0 k=0 cnt=1", j, k, fifo_count);
        end
        step();
        checks++;
        if ({j, k, busy, done} !== {4'b0101, 4'b0000, 1'b1, 1'b0}) begin
            failures++; $display("FAIL single_apply got j=%h k=%h busy=%b done=%b exp j=5 k=0 busy=1 done=0", j, k, busy, done);
        end
        step();
        checks++;
        if ({j, k, busy, done} !== {4'h0, 4'h0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL single_done got j=%h k=%h busy=%b done=%b exp j=0 k=0 busy=0 done=1", j, k, busy, done);
        end
        step();
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL single_after got busy=%b done=%b exp 00", busy, done); end
    endtask

    task automatic test_toggle_repeat();
        int nbusy = 0, ndone = 0, ntog = 0;
        set_cmd(1'b1, 2'b11, 4'hF, 4'd3);
        step();
        set_cmd(1'b0, 2'b00, 4'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({j, k, busy, done, fifo_count} !== model_vec()) begin
                failures++; $display("FAIL toggle_model cyc=%0d got=%h exp=%h", i, {j, k, busy, done, fifo_count}, model_vec());
            end
            nbusy += int'(busy);
            ndone += int'(done);
            if (j == 4'hF && k == 4'hF) ntog++;
        end
        checks++;
        if (nbusy != 4 || ntog != 4 || ndone != 1) begin
            failures++; $display("FAIL toggle_counts got busy=%0d jk=%0d done=%0d exp 4 4 1", nbusy, ntog, ndone);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        logic [7:0] exp_seq [3];
        int ndone = 0;
        exp_seq[0] = 8'hF0; exp_seq[1] = 8'h0F; exp_seq[2] = 8'hFF;
        set_cmd(1'b1, 2'b10, 4'hF, 4'd0); step();
        set_cmd(1'b1, 2'b01, 4'hF, 4'd0); step(); seq[0] = {j, k};
        set_cmd(1'b1, 2'b11, 4'hF, 4'd0); step(); seq[1] = {j, k}; ndone += int'(done);
        set_cmd(1'b0, 2'b00, 4'h0, 4'd0); step(); seq[2] = {j, k}; ndone += int'(done);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (seq[i] !== exp_seq[i]) begin failures++; $display("FAIL b2b_seq idx=%0d got=%h exp=%h", i, seq[i], exp_seq[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            step(); ndone += int'(done);
            checks++;
            if ({j, k, busy, done, fifo_count} !== model_vec()) begin
                failures++; $display("FAIL b2b_model cyc=%0d got=%h exp=%h", i, {j, k, busy, done, fifo_count}, model_vec());
            end
        end
        checks++;
        if (ndone != 3) begin failures++; $display("FAIL b2b_done got=%0d exp=3", ndone); end
    endtask

    task automatic test_fifo_full();
        int accepted = 0, maxcnt = 0;
        bit blocked = 0;
        set_cmd(1'b1, 2'b10, 4'hA, 4'd15); step();
        set_cmd(1'b0, 2'b00, 4'h0, 4'd0); step();
        for (int i = 0; i < 40 && accepted < 5; i++) begin
            set_cmd(1'b1, 2'($urandom), 4'($urandom), 4'($urandom_range(0, 2)));
            checks++;
            if (cmd_ready !== exp_ready()) begin failures++; $display("FAIL full_ready cyc=%0d got=%b exp=%b", i, cmd_ready, exp_ready()); end
            if (!cmd_ready && fifo_count == 3'd4) blocked = 1;
            step();
            accepted += int'(last_acc);
            if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
            checks++;
            if ({j, k, busy, done, fifo_count} !== model_vec()) begin
                failures++; $display("FAIL full_model cyc=%0d got=%h exp=%h", i, {j, k, busy, done, fifo_count}, model_vec());
            end
        end
        set_cmd(1'b0, 2'b00, 4'h0, 4'd0);
        checks++;
        if (accepted != 5 || maxcnt != 4 || !blocked) begin
            failures++; $display("FAIL full_summary got acc=%0d max=%0d blocked=%b exp 5 4 1", accepted, maxcnt, blocked);
        end
        for (int i = 0; i < 120 && (act || q.size() > 0 || busy); i++) begin
            step();
            checks++;
            if ({j, k, busy, done, fifo_count} !== model_vec()) begin
                failures++; $display("FAIL drain_model cyc=%0d got=%h exp=%h", i, {j, k, busy, done, fifo_count}, model_vec());
            end
        end
        checks++;
        if (busy !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL drain_timeout got busy=%b cnt=%0d exp 0 0", busy, fifo_count); end
    endtask

    task automatic test_reset_mid_apply();
        int bad = 0;
        set_cmd(1'b1, 2'b11, 4'hF, 4'd7); step();
        set_cmd(1'b1, 2'b10, 4'h3, 4'd1); step();
        set_cmd(1'b1, 2'b01, 4'hC, 4'd1); step();
        set_cmd(1'b0, 2'b00, 4'h0, 4'd0); step();
        checks++;
        if ({busy, fifo_count} !== {1'b1, 3'd2}) begin failures++; $display("FAIL mid_pre got busy=%b cnt=%0d exp 1 2", busy, fifo_count); end
        reset = 1'b0; step(); reset = 1'b1;
        checks++;
        if ({j, k, busy, done, fifo_count} !== 13'b0) begin
            failures++; $display("FAIL mid_reset got j=%h k=%h busy=%b done=%b cnt=%0d exp all zero", j, k, busy, done, fifo_count);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if ({j, k, busy, done, fifo_count} !== 13'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL mid_replay got nonzero_cycles=%0d exp 0", bad); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            set_cmd(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom_range(0, 3)));
            checks++;
            if (cmd_ready !== exp_ready()) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, cmd_ready, exp_ready()); end
            step();
            checks++;
            if ({j, k, busy, done, fifo_count} !== model_vec()) begin
                failures++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", i, {j, k, busy, done, fifo_count}, model_vec());
            end
        end
        reset = 1'b1;
        set_cmd(1'b0, 2'b00, 4'h0, 4'd0);
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_toggle_repeat();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_apply();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
